mux_sel_reg: RTL and testbench
==============================

# mux_sel_reg

Parametrised, registered N-input selector with valid/ready handshaking on every input and on the output. It generalises the CPU's fixed 4:1 clocked data mux in three ways: the data width and input count are configurable, an optional round-robin arbitration mode is added, and output backpressure is supported. It sits between pipeline producers (forwarding sources, writeback candidates) and a single consumer stage. Throughput is one transfer per clock with one cycle of latency.

## Interface
- DATA_W, 32, width of each data channel.
- N_IN, 4, number of input channels (2..16).
- SEL_W, 2, select/channel-index width; must equal clog2(N_IN), minimum 1.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = direct select via sel, 1 = round-robin (honoured only with MUX_SEL_RR_EN).
- sel  in  SEL_W  channel index in direct mode.
- in_data  in  N_IN*DATA_W  packed inputs; channel i occupies bits [i*DATA_W +: DATA_W].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready (combinational).
- out_data  out  DATA_W  registered selected data.
- out_chan  out  SEL_W  index of the channel held in out_data.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word.

## Operation
- One output register stage: out_data, out_chan, out_valid.
- load_en = !out_valid || out_ready.
- Grant vector (one-hot or zero, combinational):
  - Direct mode: grant[sel] = in_valid[sel].
  - If sel >= N_IN: no grant. The register is not loaded; if it held a word, out_valid drops after out_ready.
  - Round-robin mode: the first valid channel searching upward from rr_ptr+1, wrapping at N_IN-1 to 0. No grant if no channel is valid.
- in_ready[i] = load_en && grant[i]. An input transfer occurs when in_valid[i] && in_ready[i].
- On a clock edge with load_en:
  - If any grant: out_data is loaded from the granted channel, out_chan is loaded with its index, and out_valid is set to 1.
  - If no grant: out_valid is set to 0; out_data and out_chan hold their values.
- Without load_en (out_valid=1, out_ready=0), all output registers hold. in_ready is all zero.
- rr_ptr (SEL_W bits) is updated to the granted index only when a transfer occurs in round-robin mode. It is unchanged in direct mode.
- Changes to mode or sel take effect at the next load. rr_ptr is retained across mode changes.
- Data arithmetic: none. Indices are compared unsigned.

## Timing
- Reset (rst=1 at a clock edge) sets:
  - out_valid=0, out_data=0, out_chan=0.
  - rr_ptr=N_IN-1, so the first round-robin search starts at channel 0.
  - While rst is high, in_ready is forced to 0.
- Reset asserted mid-transfer discards the held word. No input is accepted in the reset cycle.
- Latency: an input accepted at edge k appears on out_data/out_valid after edge k.
- Full throughput: with out_ready held at 1, one word transfers per cycle.
- A simultaneous output accept and new load in the same cycle is legal and is the normal streaming case.
- Round-robin wrap: with rr_ptr=N_IN-1, the search begins at channel 0.
- Round-robin with a single valid channel: that channel is re-granted every cycle.

## Configuration
- MUX_SEL_RR_EN defined:
  - The round-robin mode, the rr_ptr register and the wrap search are compiled in.
  - mode selects between direct and round-robin operation.
- MUX_SEL_RR_EN undefined:
  - The round-robin logic and rr_ptr are absent.
  - The mode port exists but is ignored; the block always operates in direct-select mode.
  - All other behaviour is identical.

## Test plan
- Reset: drive rst=1 with all in_valid=1. Required: in_ready=0, out_valid=0, out_data=0 and out_chan=0 after the edge.
- Direct streaming:
  - Setup: mode=0, sel=2, out_ready=1, channel 2 = 0xA5A5_0002 with valid.
  - Required: out_data=0xA5A5_0002 and out_chan=2 one cycle later; only in_ready[2]=1.
  - Follow-up: with sel=5 and N_IN=4, out_valid drops to 0.
- Backpressure:
  - Setup: a word is held and out_ready=0 for 3 cycles while in_valid changes.
  - Required: out_data stable and in_ready=0 throughout.
  - Follow-up: raise out_ready with a new input present; the new word is loaded on the same edge the old one is accepted.
- Round-robin fairness (MUX_SEL_RR_EN, N_IN=4):
  - Stimulus: all channels valid, out_ready=1.
  - Required: out_chan sequence 0,1,2,3,0 over consecutive cycles.
- Round-robin skip:
  - Setup: valid on channels 1 and 3 only.
  - Required: out_chan sequence 1,3,1,3.
- Reset mid-operation: assert rst with out_valid=1 and rr_ptr=2. Required: out_valid=0, and the next round-robin grant goes to channel 0.

Source files
------------

// File: rtl/mux_sel_reg.sv
// Registered N-input selector with valid/ready on every input and on the output.
// Optional round-robin arbitration is compiled in when MUX_SEL_RR_EN is defined.
module mux_sel_reg #(
    parameter int DATA_W = 32,
    parameter int N_IN   = 4,
    parameter int SEL_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_chan,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic              load_en;
    logic              use_rr;
    logic [N_IN-1:0]   grant;
    logic              grant_any;
    logic [SEL_W-1:0]  grant_idx;
    logic [DATA_W-1:0] grant_data;

`ifdef MUX_SEL_RR_EN
    logic [SEL_W-1:0]  rr_ptr;
    assign use_rr = mode;
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign use_rr      = 1'b0;
`endif

    // The output slot is free when empty or when its word leaves this cycle.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = (rst || !load_en) ? '0 : grant;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        grant      = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        if (use_rr) begin
`ifdef MUX_SEL_RR_EN
            // Channels above rr_ptr first, then wrap to 0..rr_ptr.
            for (int i = 0; i < N_IN; i++) begin
                if (!grant_any && in_valid[i] && (SEL_W'(i) > rr_ptr)) begin
                    grant[i]   = 1'b1;
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = in_data[i*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < N_IN; i++) begin
                if (!grant_any && in_valid[i] && (SEL_W'(i) <= rr_ptr)) begin
                    grant[i]   = 1'b1;
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = in_data[i*DATA_W +: DATA_W];
                end
            end
`endif
        end else begin
            // An out-of-range sel matches no channel and so grants nothing.
            for (int i = 0; i < N_IN; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    grant[i]   = 1'b1;
                    grant_any  = 1'b1;
                    grant_idx  = SEL_W'(i);
                    grant_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_chan  <= '0;
        end else if (load_en) begin
            if (grant_any) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_chan  <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_SEL_RR_EN
    // Reset to the last channel so the first search begins at channel 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= SEL_W'(N_IN - 1);
        end else if (load_en && grant_any && use_rr) begin
            rr_ptr <= grant_idx;
        end
    end
`endif

endmodule

// File: tb/tb_mux_sel_reg.sv
// Randomised and directed bench for mux_sel_reg against a behavioural reference model.
// Uses N_IN=5 so that sel values 5..7 exercise the out-of-range case.
module tb_mux_sel_reg;

    localparam int DATA_W = 32;
    localparam int N_IN   = 5;
    localparam int SEL_W  = 3;
`ifdef MUX_SEL_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   mode;
    logic [SEL_W-1:0]       sel;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_valid;
    logic [N_IN-1:0]        in_ready;
    logic [DATA_W-1:0]      out_data;
    logic [SEL_W-1:0]       out_chan;
    logic                   out_valid;
    logic                   out_ready;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    bit          m_valid;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;

    always #5 clk = ~clk;

    mux_sel_reg #(.DATA_W(DATA_W), .N_IN(N_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the rules grant this cycle, or -1.
    function automatic int pick();
        if (RR_EN && mode) begin
            for (int d = 1; d <= N_IN; d++) begin
                int c = (m_ptr + d) % N_IN;
                if (in_valid[c]) return c;
            end
            return -1;
        end
        for (int i = 0; i < N_IN; i++)
            if (i == int'(sel) && in_valid[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] chan_data(input int c);
        logic [N_IN*DATA_W-1:0] d;
        d = in_data;
        return d[c*DATA_W +: DATA_W];
    endfunction

    task automatic set_chan(input int c, input logic [31:0] v);
        in_data[c*DATA_W +: DATA_W] = v;
    endtask

    // One clock: check in_ready mid-cycle, advance model, check outputs after the edge.
    task automatic step();
        int g;
        bit ld;
        logic [N_IN-1:0] exp_rdy;
        @(negedge clk);
        g  = pick();
        ld = !m_valid || out_ready;
        exp_rdy = '0;
        if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
        check("in_ready", in_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_data = '0; m_chan = 0; m_ptr = N_IN - 1;
        end else if (ld) begin
            if (g >= 0) begin
                m_valid = 1; m_data = chan_data(g); m_chan = g;
                if (RR_EN && mode) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_chan", out_chan, m_chan);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N_IN; i++) set_chan(i, $urandom);
    endtask

    initial begin
        logic [31:0] held;
        int exp_fair [6] = '{0, 1, 2, 3, 4, 0};
        int exp_skip [4] = '{1, 3, 1, 3};

        rst = 1'b1; mode = 1'b0; sel = '0; out_ready = 1'b1;
        in_valid = '1;
        m_valid = 0; m_data = '0; m_chan = 0; m_ptr = N_IN - 1;
        rand_data();
        @(posedge clk); #1;

        // Reset with all inputs valid.
        step();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_in_ready", in_ready, '0);
        rst = 1'b0;

        // Direct streaming on channel 2.
        mode = 1'b0; sel = 3'd2; out_ready = 1'b1;
        in_valid = N_IN'($urandom) | N_IN'(5'b00100);
        rand_data();
        set_chan(2, 32'hA5A5_0002);
        step();
        check("direct_data", out_data, 32'hA5A5_0002);
        check("direct_chan", out_chan, 3'd2);
        sel = 3'd5;
        step();
        check("sel_oob_valid", out_valid, 1'b0);

        // Backpressure: hold a word for three cycles while inputs change.
        sel = 3'd1; in_valid = '1; rand_data();
        step();
        held = out_data;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = N_IN'($urandom); sel = SEL_W'($urandom_range(0, 4)); rand_data();
            step();
            check("bp_hold", out_data, held);
        end
        out_ready = 1'b1; sel = 3'd3; in_valid = '1; rand_data();
        set_chan(3, 32'h1234_0003);
        step();
        check("bp_release", out_data, 32'h1234_0003);

        // Round-robin fairness from a fresh reset.
        rst = 1'b1; step(); rst = 1'b0;
        mode = 1'b1; in_valid = '1;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            step();
`ifdef MUX_SEL_RR_EN
            check("rr_fair", out_chan, SEL_W'(exp_fair[k]));
`endif
        end

        // Round-robin skipping invalid channels.
        in_valid = N_IN'(5'b01010);
        for (int k = 0; k < 4; k++) begin
            rand_data();
            step();
`ifdef MUX_SEL_RR_EN
            check("rr_skip", out_chan, SEL_W'(exp_skip[k]));
`endif
        end

        // Reset mid-operation with rr_ptr at 2.
        rst = 1'b1; step(); rst = 1'b0;
        in_valid = '1;
        for (int k = 0; k < 3; k++) begin rand_data(); step(); end
        rst = 1'b1; rand_data(); step();
        check("rst_mid_valid", out_valid, 1'b0);
        rst = 1'b0; rand_data(); step();
`ifdef MUX_SEL_RR_EN
        check("rst_mid_rr", out_chan, 3'd0);
`endif

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = $urandom_range(0, 1);
            sel       = SEL_W'($urandom_range(0, 7));
            in_valid  = N_IN'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
